// File: rtl/chkn_layer_scheduler.sv
// Layered-LDPC check-node scheduler. It walks the layers of each iteration,
// issues one request per layer to the check-node unit, and waits for its
// ValidOut. A one-cycle GAP follows each layer so the unit can write back its
// min-memory. A frame ends on syndrome pass, iteration limit, abort or
// watchdog expiry. A per-layer active-column mask table is loaded while idle.
module chkn_layer_scheduler #(
    parameter int NUM_LAYERS      = 8,
    parameter int WIDTH_LAYER     = 3,
    parameter int NUM_COLS        = 16,
    parameter int WIDTH_ITERATION = 5,
    parameter int TIMEOUT         = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfgWe,
    input  logic [WIDTH_LAYER-1:0]     cfgLayer,
    input  logic [NUM_COLS-1:0]        cfgMask,
    input  logic [WIDTH_LAYER:0]       numLayers,
    input  logic [WIDTH_ITERATION-1:0] maxIter,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       synOk,
    input  logic                       chknDone,
    output logic                       validOut,
    output logic [WIDTH_LAYER-1:0]     layerIdx,
    output logic [WIDTH_ITERATION-1:0] currIter,
    output logic [NUM_COLS-1:0]        activeCols,
    output logic                       busy,
    output logic                       done,
    output logic                       converged,
    output logic [WIDTH_ITERATION-1:0] iterUsed,
    output logic                       timeoutErr
);

    localparam int WD_W = $clog2(TIMEOUT);
    // The watchdog expires in the WAIT cycle where its count would reach TIMEOUT-1.
    localparam logic [WD_W-1:0]            WD_LAST   = WD_W'(TIMEOUT - 2);
    localparam logic [WD_W-1:0]            WD_ONE    = WD_W'(1);
    localparam logic [WIDTH_LAYER:0]       NL_ONE    = (WIDTH_LAYER + 1)'(1);
    localparam logic [WIDTH_LAYER:0]       NL_DEPTH  = (WIDTH_LAYER + 1)'(NUM_LAYERS);
    localparam logic [WIDTH_LAYER-1:0]     LAYER_ONE = WIDTH_LAYER'(1);
    localparam logic [WIDTH_ITERATION-1:0] ITER_ONE  = WIDTH_ITERATION'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                     state_q, state_d;
    logic [WIDTH_LAYER-1:0]     layer_q, layer_d;
    logic [WIDTH_ITERATION-1:0] iter_q, iter_d;
    logic [WIDTH_LAYER:0]       num_layers_q, num_layers_d;
    logic [WIDTH_ITERATION-1:0] max_iter_q, max_iter_d;
    logic [WD_W-1:0]            wdog_q, wdog_d;
    logic                       converged_d;
    logic                       timeout_err_q, timeout_err_d;

    logic                       valid_out_q;
    logic [WIDTH_LAYER-1:0]     layer_idx_q;
    logic [WIDTH_ITERATION-1:0] curr_iter_q;
    logic [NUM_COLS-1:0]        active_cols_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       converged_q;
    logic [WIDTH_ITERATION-1:0] iter_used_q;

    logic [NUM_COLS-1:0]        mask_q [NUM_LAYERS];
    logic                       mask_wr_s;
    logic [NUM_COLS-1:0]        issue_mask_s;

    assign mask_wr_s = cfgWe && !busy_q && ({1'b0, cfgLayer} < NL_DEPTH);

    // A write landing together with start must already be visible to the first ISSUE.
    assign issue_mask_s = (mask_wr_s && (cfgLayer == layer_d)) ? cfgMask : mask_q[layer_d];

    // Mask table storage; deliberately not reset, contents valid once written.
    always_ff @(posedge clk) begin
        if (mask_wr_s) begin
            mask_q[cfgLayer] <= cfgMask;
        end
    end

    // FSM state and frame bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            layer_q       <= '0;
            iter_q        <= '0;
            num_layers_q  <= '0;
            max_iter_q    <= '0;
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            layer_q       <= layer_d;
            iter_q        <= iter_d;
            num_layers_q  <= num_layers_d;
            max_iter_q    <= max_iter_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state logic; abort preempts every other event outside IDLE/DONE.
    always_comb begin
        state_d       = state_q;
        layer_d       = layer_q;
        iter_d        = iter_q;
        num_layers_d  = num_layers_q;
        max_iter_d    = max_iter_q;
        wdog_d        = wdog_q;
        converged_d   = 1'b0;
        timeout_err_d = timeout_err_q;
        if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d = S_DONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_layers_d  = numLayers;
                        max_iter_d    = maxIter;
                        layer_d       = '0;
                        timeout_err_d = 1'b0;
                        if ((numLayers == '0) || (maxIter == '0)) begin
                            iter_d  = '0;
                            state_d = S_DONE;
                        end else begin
                            iter_d  = ITER_ONE;
                            state_d = S_ISSUE;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ISSUE: begin
                    wdog_d  = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (chknDone) begin
                        state_d = S_GAP;
                    end else if (wdog_q == WD_LAST) begin
                        timeout_err_d = 1'b1;
                        state_d       = S_DONE;
                    end else begin
                        wdog_d = wdog_q + WD_ONE;
                    end
                end
                S_GAP: begin
                    if ({1'b0, layer_q} == (num_layers_q - NL_ONE)) begin
                        state_d = S_CHECK;
                    end else begin
                        layer_d = layer_q + LAYER_ONE;
                        state_d = S_ISSUE;
                    end
                end
                S_CHECK: begin
                    if (synOk) begin
                        converged_d = 1'b1;
                        state_d     = S_DONE;
                    end else if (iter_q == max_iter_q) begin
                        state_d = S_DONE;
                    end else begin
                        iter_d  = iter_q + ITER_ONE;
                        layer_d = '0;
                        state_d = S_ISSUE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Registered outputs, loaded from the state being entered so they align with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out_q   <= 1'b0;
            layer_idx_q   <= '0;
            curr_iter_q   <= '0;
            active_cols_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            converged_q   <= 1'b0;
            iter_used_q   <= '0;
        end else begin
            valid_out_q <= (state_d == S_ISSUE);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            converged_q <= converged_d;
            if (state_d == S_ISSUE) begin
                layer_idx_q   <= layer_d;
                curr_iter_q   <= iter_d;
                active_cols_q <= issue_mask_s;
            end
            if (state_d == S_DONE) begin
                iter_used_q <= iter_d;
            end
        end
    end

    assign validOut   = valid_out_q;
    assign layerIdx   = layer_idx_q;
    assign currIter   = curr_iter_q;
    assign activeCols = active_cols_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign converged  = converged_q;
    assign iterUsed   = iter_used_q;
    assign timeoutErr = timeout_err_q;

endmodule

// File: tb/tb_chkn_layer_scheduler.sv
// Bench for chkn_layer_scheduler: directed scenarios plus randomized frames,
// each checked against a frame-level model (nested iteration/layer loops over a
// shadow mask table, with cadence 1 + L + 1 cycles per layer).
module tb_chkn_layer_scheduler;

    logic        clk;
    logic        reset;
    logic        cfgWe;
    logic [2:0]  cfgLayer;
    logic [15:0] cfgMask;
    logic [3:0]  numLayers;
    logic [4:0]  maxIter;
    logic        start;
    logic        abort;
    logic        synOk;
    logic        chknDone;
    logic        validOut;
    logic [2:0]  layerIdx;
    logic [4:0]  currIter;
    logic [15:0] activeCols;
    logic        busy;
    logic        done;
    logic        converged;
    logic [4:0]  iterUsed;
    logic        timeoutErr;

    int total;
    int bad;
    logic [15:0] model_mask [8];

    chkn_layer_scheduler dut (
        .clk(clk), .reset(reset), .cfgWe(cfgWe), .cfgLayer(cfgLayer),
        .cfgMask(cfgMask), .numLayers(numLayers), .maxIter(maxIter),
        .start(start), .abort(abort), .synOk(synOk), .chknDone(chknDone),
        .validOut(validOut), .layerIdx(layerIdx), .currIter(currIter),
        .activeCols(activeCols), .busy(busy), .done(done),
        .converged(converged), .iterUsed(iterUsed), .timeoutErr(timeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int l, input logic [15:0] m);
        cfgWe = 1'b1; cfgLayer = 3'(l); cfgMask = m;
        step();
        cfgWe = 1'b0;
        model_mask[l] = m;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vo"}, 32'(validOut), 32'd0);
        chk({tag, "_li"}, 32'(layerIdx), 32'd0);
        chk({tag, "_ci"}, 32'(currIter), 32'd0);
        chk({tag, "_ac"}, 32'(activeCols), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_conv"}, 32'(converged), 32'd0);
        chk({tag, "_iu"}, 32'(iterUsed), 32'd0);
        chk({tag, "_to"}, 32'(timeoutErr), 32'd0);
    endtask

    // One frame: nl layers, mi iterations, synOk in CHECK of iteration pass_it
    // (0 = never), fixed latency lat_fix (0 = random), abort in WAIT of
    // (ab_it, ab_l) (ab_it = 0: none), optional mask write with start, and
    // optional ignored-event noise while busy.
    task automatic run_frame(input int nl, input int mi, input int pass_it, input int lat_fix,
                             input int ab_it, input int ab_l, input bit wr_start, input bit noise);
        int lat;
        numLayers = 4'(nl); maxIter = 5'(mi); start = 1'b1;
        if (wr_start) begin
            cfgWe = 1'b1; cfgLayer = 3'd0; cfgMask = 16'($urandom);
            model_mask[0] = cfgMask;
        end
        step();
        start = 1'b0; cfgWe = 1'b0;
        chk("to_clear", 32'(timeoutErr), 32'd0);
        chk("busy_start", 32'(busy), 32'd1);
        if (nl == 0 || mi == 0) begin
            chk("zero_vo", 32'(validOut), 32'd0);
            chk("zero_done", 32'(done), 32'd1);
            chk("zero_iu", 32'(iterUsed), 32'd0);
            chk("zero_conv", 32'(converged), 32'd0);
            step();
            chk("zero_busy", 32'(busy), 32'd0);
            return;
        end
        for (int it = 1; it <= mi; it++) begin
            for (int l = 0; l < nl; l++) begin
                chk("issue_vo", 32'(validOut), 32'd1);
                chk("issue_layer", 32'(layerIdx), 32'(l));
                chk("issue_iter", 32'(currIter), 32'(it));
                chk("issue_mask", 32'(activeCols), 32'(model_mask[l]));
                lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 6));
                if (it == ab_it && l == ab_l) begin
                    step();
                    abort = 1'b1;
                    step();
                    abort = 1'b0;
                    chk("abort_done", 32'(done), 32'd1);
                    chk("abort_iu", 32'(iterUsed), 32'(it));
                    chk("abort_conv", 32'(converged), 32'd0);
                    for (int k = 0; k < 8; k++) begin
                        step();
                        chk("abort_quiet", 32'(validOut), 32'd0);
                    end
                    return;
                end
                for (int k = 1; k <= lat; k++) begin
                    step();
                    chk("wait_vo", 32'(validOut), 32'd0);
                    chk("wait_hold", 32'(layerIdx), 32'(l));
                    if (noise) begin
                        synOk     = 1'($urandom_range(0, 1));
                        start     = 1'($urandom_range(0, 1));
                        numLayers = 4'($urandom_range(0, 8));
                        cfgWe     = 1'($urandom_range(0, 1));
                        cfgLayer  = 3'($urandom);
                        cfgMask   = 16'($urandom);
                    end
                    if (k == lat) chknDone = 1'b1;
                end
                step();
                chknDone = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                synOk = 1'b0; start = 1'b0; cfgWe = 1'b0;
                chk("gap_vo", 32'(validOut), 32'd0);
                step();
                chknDone = 1'b0;
                if (l < nl - 1) continue;
                chk("check_vo", 32'(validOut), 32'd0);
                synOk = (it == pass_it);
                step();
                synOk = 1'b0;
                if (it == pass_it || it == mi) begin
                    chk("end_done", 32'(done), 32'd1);
                    chk("end_conv", 32'(converged), 32'(it == pass_it));
                    chk("end_iu", 32'(iterUsed), 32'(it));
                    chk("end_vo", 32'(validOut), 32'd0);
                    step();
                    chk("end_done_low", 32'(done), 32'd0);
                    chk("end_busy", 32'(busy), 32'd0);
                    chk("end_iu_hold", 32'(iterUsed), 32'(it));
                    return;
                end
            end
        end
    endtask

    initial begin
        int nl;
        int mi;
        total = 0; bad = 0;
        reset = 1'b0; cfgWe = 1'b0; cfgLayer = 3'd0; cfgMask = 16'd0;
        numLayers = 4'd0; maxIter = 5'd0; start = 1'b0; abort = 1'b0;
        synOk = 1'b0; chknDone = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("rst");
        @(negedge clk);
        reset = 1'b1;
        step();

        for (int l = 0; l < 8; l++) cfg_write(l, 16'($urandom));
        cfg_write(0, 16'h00FF);
        cfg_write(1, 16'h0F0F);
        cfg_write(2, 16'hFFFF);

        // Plain two-iteration run, then early convergence.
        run_frame(3, 2, 0, 4, 0, 0, 1'b0, 1'b0);
        run_frame(3, 2, 1, 4, 0, 0, 1'b0, 1'b0);

        // Watchdog: chknDone never returns.
        numLayers = 4'd2; maxIter = 5'd3; start = 1'b1;
        step();
        start = 1'b0;
        chk("wd_issue", 32'(validOut), 32'd1);
        for (int k = 1; k < 64; k++) begin
            step();
            chk("wd_wait_done", 32'(done), 32'd0);
        end
        step();
        chk("wd_done", 32'(done), 32'd1);
        chk("wd_err", 32'(timeoutErr), 32'd1);
        chk("wd_conv", 32'(converged), 32'd0);
        chk("wd_iu", 32'(iterUsed), 32'd1);
        repeat (3) step();
        chk("wd_sticky", 32'(timeoutErr), 32'd1);
        chk("wd_idle_busy", 32'(busy), 32'd0);
        run_frame(2, 1, 0, 0, 0, 0, 1'b0, 1'b0);

        // Abort in WAIT of iteration 2, layer 1.
        run_frame(3, 2, 0, 4, 2, 1, 1'b0, 1'b0);

        // Ignored events while busy, mask write with start, empty frames.
        run_frame(4, 2, 0, 0, 0, 0, 1'b0, 1'b1);
        run_frame(2, 1, 1, 0, 0, 0, 1'b1, 1'b0);
        run_frame(0, 2, 0, 0, 0, 0, 1'b0, 1'b0);
        run_frame(2, 0, 0, 0, 0, 0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of WAIT.
        numLayers = 4'd3; maxIter = 5'd2; start = 1'b1;
        step();
        start = 1'b0;
        step();
        #2 reset = 1'b0;
        #1;
        chk_all_zero("areset");
        @(negedge clk);
        reset = 1'b1;
        step();
        run_frame(1, 1, 0, 0, 0, 0, 1'b0, 1'b0);

        // Randomized frames.
        for (int f = 0; f < 24; f++) begin
            if ($urandom_range(0, 1) == 1) cfg_write(int'($urandom_range(0, 7)), 16'($urandom));
            nl = int'($urandom_range(1, 8));
            mi = int'($urandom_range(1, 4));
            run_frame(nl, mi, int'($urandom_range(0, mi)), 0, 0, 0,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
